loop_deadtime_gen: RTL and testbench
====================================

LOOP_DEADTIME_GEN -- requirements
Module: loop_deadtime_gen

Interface
REQ-001 Parameter DT_W, default 4: width of dt_cfg.
REQ-002 Parameter MIN_ON, default 3: minimum high-side on time in clocks, legal range 1..15.
REQ-003 Port CELCLK, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port CELRSTN, input, 1: reset, asynchronous, active-low.
REQ-005 Port CELV, input, 1: cell supply tie; no logic function.
REQ-006 Port CELG, input, 1: cell ground tie; no logic function.
REQ-007 Port SUB, input, 1: substrate tie; no logic function.
REQ-008 Port pwm_n, input, 1: active-low high-side request, driven by the upstream control nand2 output, asynchronous to CELCLK.
REQ-009 Port en, input, 1: converter enable, synchronous.
REQ-010 Port dt_cfg, input, DT_W: dead time in clocks; value 0 is treated as 1.
REQ-011 Port fault, input, 1: overcurrent or UVLO fault, level, active-high.
REQ-012 Port fault_clr, input, 1: single-cycle fault-latch clear.
REQ-013 Port zcd, input, 1: synchronous zero-cross detect, active-high.
REQ-014 Port hs_on, output, 1: high-side gate enable.
REQ-015 Port ls_on, output, 1: low-side gate enable.
REQ-016 Port fault_flag, output, 1: latched fault indicator.

Function
REQ-017 pwm_n shall pass through a 2-flop synchronizer; req = NOT sync2.
REQ-018 The FSM states shall be IDLE, DT_H, HS_ON, DT_L, LS_ON, and FAULT.
REQ-019 Transition priority shall be: fault > en low > normal transitions.
REQ-020 IDLE (hs=0, ls=0): when en=1 and req=1, go to DT_H; when en=1 and req=0, go to DT_L.
REQ-021 DT_H and DT_L (hs=0, ls=0): each state shall last exactly max(dt_cfg,1) cycles, then go to HS_ON or LS_ON respectively.
REQ-022 dt_cfg shall be sampled on entry to DT_H or DT_L; changes during the dead time shall be ignored.
REQ-023 HS_ON (hs=1): go to DT_L when req=0 and the on-counter is at least MIN_ON.
REQ-024 HS_ON shall last at least MIN_ON cycles even if req drops earlier.
REQ-025 LS_ON (ls=1): go to DT_H when req=1.
REQ-026 hs_on and ls_on shall be registered FSM outputs, and shall never both be 1 in the same cycle.
REQ-027 en=0 in any state except FAULT shall go to IDLE on the next edge; both outputs shall be 0 from that edge.
REQ-028 fault=1 shall force hs_on=0 and ls_on=0 combinationally within the same cycle.
REQ-029 fault=1 shall move the FSM to FAULT on the next edge and set fault_flag=1.
REQ-030 FAULT (hs=0, ls=0): exit to IDLE only when fault_clr=1 and fault=0 in the same cycle; fault_clr shall clear fault_flag on that edge.
REQ-031 fault_clr while fault=1 shall have no effect.
REQ-032 Latency from a pwm_n edge to the start of dead time shall be 2 or 3 clocks, due to synchronizer phase.
REQ-033 The on-counter shall saturate at 15 and shall not wrap.

Reset
REQ-034 CELRSTN=0 shall immediately force: state=IDLE, synchronizer flops=1 (no request), counters=0, hs_on=0, ls_on=0, fault_flag=0.
REQ-035 A reset asserted mid-dead-time or mid-on shall drop both outputs asynchronously, with no glitch to 1.
REQ-036 After reset release, the first possible hs_on=1 shall be no earlier than 2 + max(dt_cfg,1) clocks.

Configuration
REQ-037 With macro LOOP_DT_ZCD_EN defined: in LS_ON, zcd=1 with req=0 shall go to IDLE on the next edge and drop ls_on (diode emulation).
REQ-038 With LOOP_DT_ZCD_EN defined: IDLE shall then wait for req=1 and shall not re-enter DT_L until req toggles 1 then 0.
REQ-039 Without LOOP_DT_ZCD_EN: the zcd port shall remain, but is ignored; LS_ON is left only via req, en, or fault.

Verification
REQ-040 dt_cfg=4, en=1, pwm_n held high then driven low: ls_on=1, falls, 4 cycles of both 0, then hs_on=1.
REQ-041 dt_cfg=0, pwm_n square wave with a period of 20 clocks: exactly 1 dead cycle at every transition, and never hs_on=ls_on=1.
REQ-042 MIN_ON=3, pwm_n low for 1 clock only: hs_on high for exactly 3 cycles, then 1 dead cycle (dt_cfg=1), then ls_on=1.
REQ-043 fault pulsed while hs_on=1: hs_on=0 the same cycle and fault_flag=1; fault_clr with fault=1 leaves the flag set; fault_clr with fault=0 returns to IDLE.
REQ-044 With LOOP_DT_ZCD_EN: in LS_ON, zcd=1 gives ls_on=0 next cycle and the FSM in IDLE; without the macro, ls_on stays 1.
REQ-045 CELRSTN asserted 2 cycles into a dt_cfg=8 dead time: outputs stay 0; after release, hs_on is not asserted before cycle 10.

Source files
------------

// File: rtl/loop_deadtime_gen_if.sv
// Gate-drive control bundle between a PWM controller and the dead-time generator.
// Latency: none (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
//
// Port summary (slave = dead-time generator):
//   pwm_n      : active-low high-side request, asynchronous to the cell clock
//   en         : converter enable
//   dt_cfg     : dead time in clocks (0 behaves as 1)
//   fault      : overcurrent/UVLO level, active-high
//   fault_clr  : single-cycle fault-latch clear
//   zcd        : zero-cross detect, active-high
//   hs_on      : high-side gate enable
//   ls_on      : low-side gate enable
//   fault_flag : latched fault indicator
interface loop_deadtime_gen_if #(
    parameter int DT_W = 4
);
    logic            pwm_n;
    logic            en;
    logic [DT_W-1:0] dt_cfg;
    logic            fault;
    logic            fault_clr;
    logic            zcd;
    logic            hs_on;
    logic            ls_on;
    logic            fault_flag;

    modport master (
        output pwm_n, en, dt_cfg, fault, fault_clr, zcd,
        input  hs_on, ls_on, fault_flag
    );

    modport slave (
        input  pwm_n, en, dt_cfg, fault, fault_clr, zcd,
        output hs_on, ls_on, fault_flag
    );
endinterface

// File: rtl/loop_deadtime_gen.sv
// Half-bridge dead-time generator: turns a PWM request into non-overlapping hs/ls gate enables.
// Latency: pwm_n edge to start of dead time 2-3 clocks (2-flop synchronizer), dead time max(dt_cfg,1).
// Backpressure: none; fault drops both gates combinationally, en low returns to IDLE next edge.
//
// Ports:
//   CELCLK  : sole clock, rising edge
//   CELRSTN : asynchronous active-low reset
//   CELV, CELG, SUB : supply/ground/substrate ties, no logic function
//   bus     : loop_deadtime_gen_if.slave (pwm_n, en, dt_cfg, fault, fault_clr, zcd -> hs_on, ls_on, fault_flag)
// Build option: define LOOP_DT_ZCD_EN to enable diode emulation (zcd ends the low-side phase).
module loop_deadtime_gen #(
    parameter int DT_W   = 4,
    parameter int MIN_ON = 3
) (
    input  logic                 CELCLK,
    input  logic                 CELRSTN,
    input  logic                 CELV,
    input  logic                 CELG,
    input  logic                 SUB,
    loop_deadtime_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DT_H,
        ST_HS_ON,
        ST_DT_L,
        ST_LS_ON,
        ST_FAULT
    } state_t;

    localparam logic [3:0] ON_MIN = 4'(MIN_ON);
    localparam logic [3:0] ON_SAT = 4'd15;

    state_t          state_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            req;
    logic [DT_W-1:0] dt_cnt_q;
    logic [DT_W-1:0] dt_load_d;
    logic [3:0]      on_cnt_q;
    logic            hs_q;
    logic            ls_q;
    logic            fault_flag_q;
`ifdef LOOP_DT_ZCD_EN
    // Set when diode emulation ended the low-side phase; IDLE then waits for a
    // fresh high-side request instead of re-entering DT_L.
    logic            zcd_hold_q;
`endif

    // Tie pins carry no logic; fold them into one sink so they are visibly consumed.
    logic unused_ties;
    assign unused_ties = ^{CELV, CELG, SUB, bus.zcd};

    // Synchronizer resets to 1 so that reset reads as "no request".
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.pwm_n;
            sync2_q <= sync1_q;
        end
    end

    assign req = ~sync2_q;

    // Counter holds remaining-cycles-minus-one, so dt_cfg of 0 and 1 both give one dead cycle.
    assign dt_load_d = (bus.dt_cfg == '0) ? '0 : bus.dt_cfg - DT_W'(1);

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_q      <= ST_IDLE;
            dt_cnt_q     <= '0;
            on_cnt_q     <= '0;
            hs_q         <= 1'b0;
            ls_q         <= 1'b0;
            fault_flag_q <= 1'b0;
`ifdef LOOP_DT_ZCD_EN
            zcd_hold_q   <= 1'b0;
`endif
        end else if (bus.fault) begin
            state_q      <= ST_FAULT;
            hs_q         <= 1'b0;
            ls_q         <= 1'b0;
            fault_flag_q <= 1'b1;
        end else if (state_q == ST_FAULT) begin
            // fault is known low here, so a clear request is honoured.
            if (bus.fault_clr) begin
                state_q      <= ST_IDLE;
                fault_flag_q <= 1'b0;
            end
        end else if (!bus.en) begin
            state_q <= ST_IDLE;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q  <= ST_DT_H;
                        dt_cnt_q <= dt_load_d;
`ifdef LOOP_DT_ZCD_EN
                        zcd_hold_q <= 1'b0;
                    end else if (!zcd_hold_q) begin
`else
                    end else begin
`endif
                        state_q  <= ST_DT_L;
                        dt_cnt_q <= dt_load_d;
                    end
                end
                ST_DT_H: begin
                    if (dt_cnt_q == '0) begin
                        state_q  <= ST_HS_ON;
                        hs_q     <= 1'b1;
                        on_cnt_q <= 4'd1;
                    end else begin
                        dt_cnt_q <= dt_cnt_q - DT_W'(1);
                    end
                end
                ST_HS_ON: begin
                    // on_cnt_q counts cycles already spent high, including this one.
                    if (on_cnt_q >= ON_MIN && !req) begin
                        state_q  <= ST_DT_L;
                        hs_q     <= 1'b0;
                        dt_cnt_q <= dt_load_d;
                    end else if (on_cnt_q != ON_SAT) begin
                        on_cnt_q <= on_cnt_q + 4'd1;
                    end
                end
                ST_DT_L: begin
                    if (dt_cnt_q == '0) begin
                        state_q <= ST_LS_ON;
                        ls_q    <= 1'b1;
                    end else begin
                        dt_cnt_q <= dt_cnt_q - DT_W'(1);
                    end
                end
                ST_LS_ON: begin
`ifdef LOOP_DT_ZCD_EN
                    if (bus.zcd && !req) begin
                        state_q    <= ST_IDLE;
                        ls_q       <= 1'b0;
                        zcd_hold_q <= 1'b1;
                    end else
`endif
                    if (req) begin
                        state_q  <= ST_DT_H;
                        ls_q     <= 1'b0;
                        dt_cnt_q <= dt_load_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hs_q    <= 1'b0;
                    ls_q    <= 1'b0;
                end
            endcase
        end
    end

    // fault gates the registered enables so the bridge turns off in the same cycle.
    assign bus.hs_on      = hs_q & ~bus.fault;
    assign bus.ls_on      = ls_q & ~bus.fault;
    assign bus.fault_flag = fault_flag_q;

endmodule

// File: tb/tb_loop_deadtime_gen.sv
// Self-checking bench for loop_deadtime_gen: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_loop_deadtime_gen;

    localparam int DT_W   = 4;
    localparam int MIN_ON = 3;

    logic CELCLK  = 1'b0;
    logic CELRSTN = 1'b0;
    logic CELV    = 1'b1;
    logic CELG    = 1'b0;
    logic SUB     = 1'b0;

    loop_deadtime_gen_if #(.DT_W(DT_W)) bus ();

    loop_deadtime_gen #(.DT_W(DT_W), .MIN_ON(MIN_ON)) dut (
        .CELCLK  (CELCLK),
        .CELRSTN (CELRSTN),
        .CELV    (CELV),
        .CELG    (CELG),
        .SUB     (SUB),
        .bus     (bus)
    );

    always #5 CELCLK = ~CELCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Bridge phases described by what the gates are doing, with plain integer timers.
    typedef enum int {M_OFF, M_GAP_TO_HI, M_HI, M_GAP_TO_LO, M_LO, M_TRIP} mphase_t;

    mphase_t m_phase;
    int      m_gap;     // dead cycles still to serve, including the current one
    int      m_age;     // cycles spent high so far
    bit      m_flag;
    bit      m_hold;    // waiting for a new high request after a zero-cross exit
    bit      pwm_seen[2]; // pwm_n as captured by the last two edges; [1] is the older

    function automatic int dt_eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_phase = M_OFF;
        m_gap = 0;
        m_age = 0;
        m_flag = 1'b0;
        m_hold = 1'b0;
        pwm_seen[0] = 1'b1;
        pwm_seen[1] = 1'b1;
    endtask

    task automatic model_step();
        bit req;
        req = !pwm_seen[1];
        if (bus.fault) begin
            m_phase = M_TRIP;
            m_flag = 1'b1;
        end else if (m_phase == M_TRIP) begin
            if (bus.fault_clr) begin
                m_phase = M_OFF;
                m_flag = 1'b0;
            end
        end else if (!bus.en) begin
            m_phase = M_OFF;
        end else begin
            case (m_phase)
                M_OFF: begin
                    if (req) begin
                        m_hold = 1'b0;
                        m_phase = M_GAP_TO_HI;
                        m_gap = dt_eff(int'(bus.dt_cfg));
                    end else if (!m_hold) begin
                        m_phase = M_GAP_TO_LO;
                        m_gap = dt_eff(int'(bus.dt_cfg));
                    end
                end
                M_GAP_TO_HI: begin
                    m_gap--;
                    if (m_gap == 0) begin
                        m_phase = M_HI;
                        m_age = 1;
                    end
                end
                M_HI: begin
                    if (m_age >= MIN_ON && !req) begin
                        m_phase = M_GAP_TO_LO;
                        m_gap = dt_eff(int'(bus.dt_cfg));
                    end else if (m_age < 15) begin
                        m_age++;
                    end
                end
                M_GAP_TO_LO: begin
                    m_gap--;
                    if (m_gap == 0) m_phase = M_LO;
                end
                M_LO: begin
`ifdef LOOP_DT_ZCD_EN
                    if (bus.zcd && !req) begin
                        m_phase = M_OFF;
                        m_hold = 1'b1;
                    end else
`endif
                    if (req) begin
                        m_phase = M_GAP_TO_HI;
                        m_gap = dt_eff(int'(bus.dt_cfg));
                    end
                end
                default: m_phase = M_OFF;
            endcase
        end
        pwm_seen[1] = pwm_seen[0];
        pwm_seen[0] = bus.pwm_n;
    endtask

    // ---------------- per-cycle compare + trace ----------------
    bit tr_hs[$];
    bit tr_ls[$];

    // Entered just after a rising edge: compare at the falling edge, then advance
    // the model across the next rising edge and return 1 time unit after it.
    task automatic cycle();
        @(negedge CELCLK);
        check_eq("hs_on",      bus.hs_on,      (m_phase == M_HI) && !bus.fault);
        check_eq("ls_on",      bus.ls_on,      (m_phase == M_LO) && !bus.fault);
        check_eq("fault_flag", bus.fault_flag, m_flag);
        check_eq("no_overlap", bus.hs_on & bus.ls_on, 1'b0);
        tr_hs.push_back(bus.hs_on);
        tr_ls.push_back(bus.ls_on);
        if (CELRSTN) model_step();
        else         model_reset();
        @(posedge CELCLK);
        #1;
    endtask

    function automatic int first_at(input bit q[$], input bit v, input int from);
        for (int i = from; i < q.size(); i++) begin
            if (q[i] == v) return i;
        end
        return -1;
    endfunction

    int fall_idx, hs_idx, last_on, dead_run, n_trans, hs_cnt, now_on;

    initial begin
        bus.pwm_n = 1'b1;
        bus.en = 1'b0;
        bus.dt_cfg = '0;
        bus.fault = 1'b0;
        bus.fault_clr = 1'b0;
        bus.zcd = 1'b0;
        model_reset();

        // Reset state
        repeat (3) cycle();
        check_eq("rst_hs", bus.hs_on, 1'b0);
        check_eq("rst_ls", bus.ls_on, 1'b0);
        check_eq("rst_flag", bus.fault_flag, 1'b0);

        // Low side first, then request high with dt_cfg=4
        bus.dt_cfg = 4'd4;
        bus.en = 1'b1;
        CELRSTN = 1'b1;
        repeat (12) cycle();
        check_eq("b_ls_steady", bus.ls_on, 1'b1);
        tr_hs.delete(); tr_ls.delete();
        bus.pwm_n = 1'b0;
        repeat (12) cycle();
        fall_idx = first_at(tr_ls, 1'b0, 0);
        hs_idx = first_at(tr_hs, 1'b1, 0);
        check_eq("b_sync_latency", (fall_idx >= 2 && fall_idx <= 3), 1'b1);
        check_eq("b_dead_cycles", hs_idx - fall_idx, 4);

        // dt_cfg=0 square wave, period 20: one dead cycle per transition
        bus.dt_cfg = 4'd0;
        tr_hs.delete(); tr_ls.delete();
        for (int k = 0; k < 120; k++) begin
            bus.pwm_n = ((k / 10) % 2) != 0;
            cycle();
        end
        last_on = 0; dead_run = 0; n_trans = 0;
        for (int i = 0; i < tr_hs.size(); i++) begin
            if (tr_hs[i] || tr_ls[i]) begin
                now_on = tr_hs[i] ? 1 : 2;
                if (last_on != 0 && now_on != last_on) begin
                    n_trans++;
                    check_eq("c_dead_len", dead_run, 1);
                end
                last_on = now_on;
                dead_run = 0;
            end else begin
                dead_run++;
            end
        end
        check_eq("c_transitions", n_trans >= 10, 1'b1);

        // One-clock request: minimum on time, then dt_cfg=1 back to low side
        bus.dt_cfg = 4'd1;
        bus.pwm_n = 1'b1;
        repeat (10) cycle();
        check_eq("d_ls_before", bus.ls_on, 1'b1);
        tr_hs.delete(); tr_ls.delete();
        bus.pwm_n = 1'b0;
        cycle();
        bus.pwm_n = 1'b1;
        repeat (12) cycle();
        hs_idx = first_at(tr_hs, 1'b1, 0);
        hs_cnt = 0;
        foreach (tr_hs[i]) hs_cnt += int'(tr_hs[i]);
        check_eq("d_hs_found", hs_idx >= 1, 1'b1);
        check_eq("d_hs_len", hs_cnt, MIN_ON);
        if (hs_idx >= 1 && hs_idx + 4 < tr_hs.size()) begin
            check_eq("d_dead_after", tr_hs[hs_idx+3] | tr_ls[hs_idx+3], 1'b0);
            check_eq("d_ls_back", tr_ls[hs_idx+4], 1'b1);
            check_eq("d_dead_before", tr_hs[hs_idx-1] | tr_ls[hs_idx-1], 1'b0);
        end

        // Fault while high side on
        bus.dt_cfg = 4'd2;
        bus.pwm_n = 1'b0;
        repeat (12) cycle();
        check_eq("e_hs_before", bus.hs_on, 1'b1);
        bus.fault = 1'b1;
        #1;
        check_eq("e_hs_comb_off", bus.hs_on, 1'b0);
        cycle();
        check_eq("e_flag_set", bus.fault_flag, 1'b1);
        bus.fault_clr = 1'b1;
        cycle();
        bus.fault_clr = 1'b0;
        cycle();
        check_eq("e_clr_ignored", bus.fault_flag, 1'b1);
        bus.fault = 1'b0;
        bus.fault_clr = 1'b1;
        cycle();
        bus.fault_clr = 1'b0;
        check_eq("e_flag_cleared", bus.fault_flag, 1'b0);
        check_eq("e_idle_hs", bus.hs_on, 1'b0);
        check_eq("e_idle_ls", bus.ls_on, 1'b0);

        // Zero-cross while low side on
        bus.dt_cfg = 4'd1;
        bus.pwm_n = 1'b1;
        repeat (12) cycle();
        check_eq("f_ls_before", bus.ls_on, 1'b1);
        bus.zcd = 1'b1;
        cycle();
        bus.zcd = 1'b0;
`ifdef LOOP_DT_ZCD_EN
        check_eq("f_zcd_ls", bus.ls_on, 1'b0);
        repeat (5) cycle();
        check_eq("f_zcd_hold", bus.ls_on, 1'b0);
`else
        check_eq("f_zcd_ls", bus.ls_on, 1'b1);
        repeat (5) cycle();
        check_eq("f_zcd_hold", bus.ls_on, 1'b1);
`endif

        // Reset two cycles into a dt_cfg=8 dead time
        bus.dt_cfg = 4'd8;
        bus.pwm_n = 1'b0;
        repeat (20) cycle();
        bus.pwm_n = 1'b1;
        repeat (20) cycle();
        check_eq("g_ls_before", bus.ls_on, 1'b1);
        bus.pwm_n = 1'b0;
        repeat (3) cycle();
        check_eq("g_in_dead", bus.hs_on | bus.ls_on, 1'b0);
        repeat (2) cycle();
        #2;
        CELRSTN = 1'b0;
        #1;
        check_eq("g_rst_hs", bus.hs_on, 1'b0);
        check_eq("g_rst_ls", bus.ls_on, 1'b0);
        check_eq("g_rst_flag", bus.fault_flag, 1'b0);
        model_reset();
        repeat (2) cycle();
        CELRSTN = 1'b1;
        tr_hs.delete(); tr_ls.delete();
        repeat (30) cycle();
        hs_idx = first_at(tr_hs, 1'b1, 0);
        check_eq("g_hs_seen", hs_idx >= 0, 1'b1);
        check_eq("g_hs_not_before_10", hs_idx >= 10, 1'b1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) bus.pwm_n = ~bus.pwm_n;
            bus.en = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) bus.dt_cfg = DT_W'($urandom_range(0, 5));
            bus.fault = ($urandom_range(0, 199) == 0);
            bus.fault_clr = ($urandom_range(0, 9) == 0);
            bus.zcd = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
